l2_mem_responder: RTL and testbench

Responder side of the L1-to-next-level request/ready interface: accepts single-word read/write requests from an L1 cache and completes each one after a fixed, parameterised latency with a one-cycle `ready` pulse. It sits below `L1_cache` as the word-addressed backing store that benches and the L2 integration use in place of a real L2. It holds a word array and flags out-of-range accesses through `hit`. It also counts completed accesses for bench bookkeeping.

---
 rtl/l2_mem_responder.sv | 133 +++++++++++++
 tb/tb_l2_mem_responder.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/l2_mem_responder.sv
// Word-addressed backing store answering L1 read/write requests after a fixed latency
// with a one-cycle ready pulse; out-of-range accesses complete with hit = 0.
module l2_mem_responder #(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDR_WIDTH    = 32,
  parameter int DEPTH_WORDS   = 4096,
  parameter int READ_LATENCY  = 4,
  parameter int WRITE_LATENCY = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic [DATA_WIDTH-1:0] data_out,
  input  logic                  read,
  input  logic                  write,
  output logic                  ready,
  output logic                  hit,
  output logic [15:0]           access_count
);

  localparam int IDX_W   = $clog2(DEPTH_WORDS);
  localparam int WIDX_W  = ADDR_WIDTH - 2;
  localparam int MAX_LAT = (READ_LATENCY > WRITE_LATENCY) ? READ_LATENCY : WRITE_LATENCY;
  localparam int CNT_W   = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_BUSY    = 2'd1;
  localparam logic [1:0] S_RESP    = 2'd2;
  localparam logic [1:0] S_RELEASE = 2'd3;

  logic [1:0]            state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [WIDX_W-1:0]     widx_q, widx_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                  is_write_q, is_write_d;
  logic                  ready_q, ready_d;
  logic                  hit_q, hit_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [15:0]           count_q, count_d;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH_WORDS];
  logic [DEPTH_WORDS-1:0] valid_q;

  logic             in_range;
  logic [IDX_W-1:0] mem_idx;
  logic             complete;
  logic             commit;
  logic             addr_lsb_unused;

  assign addr_lsb_unused = ^addr[1:0];
  assign in_range = (widx_q < WIDX_W'(DEPTH_WORDS));
  assign mem_idx  = widx_q[IDX_W-1:0];
  assign complete = (state_q == S_BUSY) && (cnt_q == '0);
  assign commit   = complete && is_write_q && in_range;

  always_comb begin
    // NOTE: every next-state signal gets a default first so no path leaves one unassigned (no latches).
    state_d    = state_q;
    cnt_d      = cnt_q;
    widx_d     = widx_q;
    wdata_d    = wdata_q;
    is_write_d = is_write_q;
    ready_d    = 1'b0;
    hit_d      = 1'b0;
    rdata_d    = rdata_q;
    count_d    = count_q;
    case (state_q)
      S_IDLE: begin
        if (read || write) begin
          widx_d     = addr[ADDR_WIDTH-1:2];
          wdata_d    = data_in;
          is_write_d = write;
          cnt_d      = write ? CNT_W'(WRITE_LATENCY - 1) : CNT_W'(READ_LATENCY - 1);
          state_d    = S_BUSY;
        end
      end
      S_BUSY: begin
        if (cnt_q == '0) begin
          state_d = S_RESP;
          ready_d = 1'b1;
          hit_d   = in_range;
          count_d = count_q + 16'd1;
          if (!is_write_q)
            rdata_d = (in_range && valid_q[mem_idx]) ? mem_q[mem_idx] : '0;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_RESP:    state_d = (read || write) ? S_RELEASE : S_IDLE;
      S_RELEASE: if (!read && !write) state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (!rst_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      widx_q     <= '0;
      wdata_q    <= '0;
      is_write_q <= 1'b0;
      ready_q    <= 1'b0;
      hit_q      <= 1'b0;
      rdata_q    <= '0;
      count_q    <= '0;
      valid_q    <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      widx_q     <= widx_d;
      wdata_q    <= wdata_d;
      is_write_q <= is_write_d;
      ready_q    <= ready_d;
      hit_q      <= hit_d;
      rdata_q    <= rdata_d;
      count_q    <= count_d;
      if (commit) valid_q[mem_idx] <= 1'b1;
    end
  end

  // NOTE: the word array itself is never reset; clearing the per-word valid bits makes every word read as 0.
  always_ff @(posedge clk) begin
    if (rst_n && commit) mem_q[mem_idx] <= wdata_q;
  end

  assign data_out     = rdata_q;
  assign ready        = ready_q;
  assign hit          = hit_q;
  assign access_count = count_q;

endmodule

// File: tb/tb_l2_mem_responder.sv
// Randomized and directed bench for l2_mem_responder: a driver queues expected
// completions from a reference model, a monitor checks every ready pulse.
module tb_l2_mem_responder;

  localparam int DW    = 32;
  localparam int AW    = 32;
  localparam int DEPTH = 4096;
  localparam int RL    = 4;
  localparam int WL    = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [AW-1:0] addr = '0;
  logic [DW-1:0] data_in = '0;
  logic [DW-1:0] data_out;
  logic          read = 1'b0;
  logic          write = 1'b0;
  logic          ready;
  logic          hit;
  logic [15:0]   access_count;

  l2_mem_responder #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH_WORDS(DEPTH),
    .READ_LATENCY(RL), .WRITE_LATENCY(WL)
  ) dut (
    .clk(clk), .rst_n(rst_n), .addr(addr), .data_in(data_in), .data_out(data_out),
    .read(read), .write(write), .ready(ready), .hit(hit), .access_count(access_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit          exp_hit;
    logic [31:0] exp_data;
    logic [15:0] exp_count;
    int          exp_edge;
  } exp_t;

  exp_t exp_q[$];

  // Reference model: plain word map, completion counter, last read result.
  logic [31:0] model_mem [int];
  logic [15:0] model_count = '0;
  logic [31:0] last_rdata  = '0;

  int checks = 0;
  int passes = 0;

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual === expected) passes++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, actual, expected, cyc);
  endtask

  always @(negedge clk) begin
    if (ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_ready", 32'(ready), 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("ready_edge", 32'(cyc), 32'(e.exp_edge));
        check("hit", 32'(hit), 32'(e.exp_hit));
        check("data_out", data_out, e.exp_data);
        check("access_count", 32'(access_count), 32'(e.exp_count));
      end
    end else if (rst_n) begin
      check("hit_idle", 32'(hit), 32'd0);
    end
  end

  function automatic logic [31:0] model_read(input int idx);
    return model_mem.exists(idx) ? model_mem[idx] : 32'd0;
  endfunction

  // Issue one request (caller is at a negedge with the DUT idle) and follow the requester rules.
  task automatic issue(input bit do_rd, input bit do_wr, input logic [31:0] a,
                       input logic [31:0] d, input int hold_extra);
    exp_t e;
    longint idx;
    bit inr;
    int n;
    idx = longint'(a >> 2);
    inr = idx < DEPTH;
    model_count = model_count + 16'd1;
    if (do_wr) begin
      if (inr) model_mem[int'(idx)] = d;
      e.exp_edge = cyc + 1 + WL;
    end else begin
      last_rdata = inr ? model_read(int'(idx)) : 32'd0;
      e.exp_edge = cyc + 1 + RL;
    end
    e.exp_hit   = inr;
    e.exp_data  = last_rdata;
    e.exp_count = model_count;
    exp_q.push_back(e);
    read = do_rd; write = do_wr; addr = a; data_in = d;
    n = 0;
    @(negedge clk);
    while (!ready && n < 30) begin
      @(negedge clk);
      n++;
    end
    check("ready_seen", 32'(ready), 32'd1);
    repeat (hold_extra) @(negedge clk);
    @(negedge clk);
    read = 1'b0; write = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int a_start;
    repeat (3) @(negedge clk);
    check("rst_ready", 32'(ready), 32'd0);
    check("rst_hit", 32'(hit), 32'd0);
    check("rst_data_out", data_out, 32'd0);
    check("rst_access_count", 32'(access_count), 32'd0);
    rst_n = 1'b1;

    issue(0, 1, 32'h0000_0040, 32'hDEADBEEF, 0);
    issue(1, 0, 32'h0000_0040, 32'h0, 0);
    issue(0, 1, 32'h0000_0040, 32'h11223344, 0);
    issue(1, 0, 32'h0000_0043, 32'h0, 0);
    issue(1, 0, 32'h0000_4000, 32'h0, 0);
    issue(0, 1, 32'h0000_4000, 32'hAAAA5555, 0);
    issue(1, 0, 32'h0000_0000, 32'h0, 0);
    issue(1, 1, 32'h0000_0010, 32'h12345678, 0);
    issue(1, 0, 32'h0000_0010, 32'h0, 3);
    issue(1, 0, 32'h0000_0040, 32'h0, 0);

    // Reset lands on the edge that would have completed a write: nothing commits.
    write = 1'b1; addr = 32'h0000_0020; data_in = 32'hCAFEF00D;
    a_start = cyc + 1;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0; write = 1'b0;
    @(negedge clk);
    check("rst_mid_ready", 32'(ready), 32'd0);
    check("rst_mid_cycle", 32'(cyc), 32'(a_start + WL));
    rst_n = 1'b1;
    model_mem.delete();
    model_count = '0;
    last_rdata  = '0;
    check("rst_mid_access_count", 32'(access_count), 32'd0);
    issue(1, 0, 32'h0000_0020, 32'h0, 0);
    issue(1, 0, 32'h0000_0040, 32'h0, 0);

    for (int i = 0; i < 40; i++) begin
      int op;
      int widx;
      logic [31:0] a;
      op   = $urandom_range(0, 2);
      widx = ($urandom_range(0, 9) == 0) ? DEPTH + $urandom_range(0, 7) : $urandom_range(0, 15);
      a    = (32'(widx) << 2) | 32'($urandom_range(0, 3));
      issue(op != 1, op != 0, a, $urandom, $urandom_range(0, 2));
    end

    repeat (5) @(negedge clk);
    check("pending_completions", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
